// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-port bundle for mem_access_unit.
//
// Handshake: a request transfers on the rising clock edge where req_valid and
// req_ready are both 1; req_* are only sampled on that edge. resp_valid is a
// single-cycle pulse with no backpressure; resp_data/resp_error are
// meaningful only while it is high. The RAM side reads combinationally
// (ram_out follows ram_address) and commits a write on the edge where
// ram_write_enable is 1.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [31:0]           req_data;

    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  resp_error;

    logic                  ram_write_enable;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [31:0]           ram_in;
    logic [31:0]           ram_out;

    // Pipeline plus RAM: issues requests, consumes responses, serves the RAM.
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_address, req_data,
        input  req_ready, resp_valid, resp_data, resp_error,
        input  ram_write_enable, ram_address, ram_in,
        output ram_out
    );

    // The access unit itself.
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_address, req_data,
        output req_ready, resp_valid, resp_data, resp_error,
        output ram_write_enable, ram_address, ram_in,
        input  ram_out
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a word-wide RAM with
// combinational read and clocked write. Sub-word stores are done as a
// read-modify-write; misaligned or illegal-size requests answer with an
// error and never touch the RAM.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus,
    output logic [2:0]       o_dbg_state
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;
    logic [31:0]           r_merge;
    logic [31:0]           r_resp_data;
    logic                  r_resp_error;

    logic                  w_accept;
    logic                  w_error;
    logic                  w_ram_active;
    logic [ADDR_WIDTH-1:0] w_aligned;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_lane;
    logic [31:0]           w_merged;

    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_error   = (bus.req_size == 2'b11)
                    || (bus.req_size == 2'b01 && bus.req_address[0])
                    || (bus.req_size == 2'b10 && bus.req_address[1:0] != 2'b00);
    assign w_aligned = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    // Little-endian lane extraction with sign/zero extension for loads.
    always_comb begin
        w_byte = bus.ram_out[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? bus.ram_out[31:16] : bus.ram_out[15:0];
        w_lane = bus.ram_out;
        case (r_size)
            2'b00:   w_lane = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_lane = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_lane = bus.ram_out;
        endcase
    end

    // Replace the addressed byte/half of the current RAM word with store data.
    always_comb begin
        w_merged = bus.ram_out;
        if (r_size == 2'b00) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_data[7:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_data[15:0];
        end
    end

    // Next-state decode; one request in flight, ready only in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_error)                     w_next_state = ST_RESP;
                    else if (!bus.req_write)         w_next_state = ST_LOAD;
                    else if (bus.req_size == 2'b10)  w_next_state = ST_WRITE;
                    else                             w_next_state = ST_RMW_READ;
                end
            end
            ST_LOAD:     w_next_state = ST_RESP;
            ST_RMW_READ: w_next_state = ST_WRITE;
            ST_WRITE:    w_next_state = ST_RESP;
            ST_RESP:     w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Request latch, merge register and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_data       <= 32'd0;
            r_merge      <= 32'd0;
            r_resp_data  <= 32'd0;
            r_resp_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_size       <= bus.req_size;
                r_unsigned   <= bus.req_unsigned;
                r_addr       <= bus.req_address;
                r_data       <= bus.req_data;
                r_merge      <= bus.req_data;
                r_resp_data  <= 32'd0;
                r_resp_error <= w_error;
            end
            if (r_state == ST_LOAD)     r_resp_data <= w_lane;
            if (r_state == ST_RMW_READ) r_merge     <= w_merged;
        end
    end

    // RAM and response outputs decode from registered state; reset gates the
    // write strobe directly so an interrupted WRITE never commits.
    assign w_ram_active         = (r_state == ST_LOAD) || (r_state == ST_RMW_READ) || (r_state == ST_WRITE);
    assign bus.req_ready        = (r_state == ST_IDLE) && reset;
    assign bus.resp_valid       = (r_state == ST_RESP);
    assign bus.resp_error       = (r_state == ST_RESP) && r_resp_error;
    assign bus.resp_data        = (r_state == ST_RESP) ? r_resp_data : 32'd0;
    assign bus.ram_address      = w_ram_active ? w_aligned : '0;
    assign bus.ram_write_enable = (r_state == ST_WRITE) && reset;
    assign bus.ram_in           = (r_state == ST_WRITE) ? r_merge : 32'd0;
    assign o_dbg_state          = r_state;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: 64-word RAM model, directed scenarios and a
// random load/store mix compared against a word-array reference model.
module tb_mem_access_unit;
    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;

    mem_access_unit_if #(.ADDR_WIDTH(16)) bus ();

    mem_access_unit #(.ADDR_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [31:0] ram_mem [0:63];
    int          n_writes = 0;
    int          n_resp   = 0;

    assign bus.ram_out = ram_mem[bus.ram_address[7:2]];

    always @(posedge clk) begin
        if (bus.ram_write_enable) begin
            ram_mem[bus.ram_address[7:2]] <= bus.ram_in;
            n_writes++;
        end
        if (bus.resp_valid) n_resp++;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic is_err(input logic [1:0] sz, input int a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic uns, input int off);
        int v;
        if (sz == 2'd0) begin
            v = int'((word >> (8 * off)) & 32'hFF);
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = int'((word >> (8 * off)) & 32'hFFFF);
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            return word;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                                input int off, input logic [31:0] d);
        logic [31:0] mask;
        if (sz == 2'd0)      mask = 32'hFF << (8 * off);
        else if (sz == 2'd1) mask = 32'hFFFF << (8 * off);
        else                 mask = 32'hFFFF_FFFF;
        return (word & ~mask) | ((d << (8 * off)) & mask);
    endfunction

    // ---------------- driver ----------------
    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_address  = 16'($urandom);
        bus.req_data     = $urandom;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [15:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic rerr, output int lat);
        int waited;
        waited = 0;
        rdata  = 32'd0;
        rerr   = 1'b0;
        lat    = 0;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_address  = a;
        bus.req_data     = d;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            idle_inputs();
        end else begin
            @(posedge clk);
            #1;
            idle_inputs();
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                @(negedge clk);
                if (bus.resp_valid) begin
                    lat   = c;
                    rdata = bus.resp_data;
                    rerr  = bus.resp_error;
                end
            end
            if (lat == 0) begin
                check_eq("resp_timeout", 32'd0, 32'd1);
            end else begin
                @(negedge clk);
                check_eq("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
                check_eq("ready_after_resp", 32'(bus.req_ready), 32'd1);
            end
        end
    endtask

    task automatic run_op(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [15:0] a, input logic [31:0] d);
        logic        err;
        logic [31:0] exp_data;
        logic [31:0] got;
        logic        gerr;
        int          lat;
        int          exp_lat;
        int          w0;
        int          idx;
        idx      = (int'(a) / 4) % 64;
        err      = is_err(sz, int'(a));
        exp_data = 32'd0;
        if (!err && !w) exp_data = model_load(ref_mem[idx], sz, uns, int'(a) % 4);
        exp_lat  = err ? 1 : ((w && sz != 2'd2) ? 3 : 2);
        exp_q.push_back(exp_data);
        w0 = n_writes;
        do_req(w, sz, uns, a, d, got, gerr, lat);
        check_eq("resp_data", got, exp_q.pop_front());
        check_eq("resp_error", 32'(gerr), 32'(err));
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("write_count", 32'(n_writes - w0), (w && !err) ? 32'd1 : 32'd0);
        if (w && !err) ref_mem[idx] = model_store(ref_mem[idx], sz, int'(a) % 4, d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          acc_cnt;
        int          acc_cyc [2];
        int          resp_cyc [2];
        int          rcnt;
        int          resp0;
        logic [31:0] old_word;

        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
        repeat (3) @(negedge clk);

        // Reset values while held low.
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_resp_data", bus.resp_data, 32'd0);
        check_eq("rst_resp_error", 32'(bus.resp_error), 32'd0);
        check_eq("rst_ram_we", 32'(bus.ram_write_enable), 32'd0);
        check_eq("rst_ram_addr", 32'(bus.ram_address), 32'd0);
        check_eq("rst_ram_in", bus.ram_in, 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("ready_after_release", 32'(bus.req_ready), 32'd1);

        // Fill every RAM word through the unit so both memories agree.
        for (int i = 0; i < 64; i++) run_op(1'b1, 2'd2, 1'b0, 16'(i * 4), $urandom);

        // Word store then load.
        run_op(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
        check_eq("ram_sw_10", ram_mem[4], 32'hDEADBEEF);
        run_op(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0);

        // Byte store and signed/unsigned byte loads.
        run_op(1'b1, 2'd0, 1'b0, 16'h0011, 32'h000000AA);
        check_eq("ram_sb_11", ram_mem[4], 32'hDEADAAEF);
        run_op(1'b0, 2'd0, 1'b0, 16'h0011, 32'd0);
        run_op(1'b0, 2'd0, 1'b1, 16'h0011, 32'd0);

        // Halfword store and loads.
        run_op(1'b1, 2'd1, 1'b0, 16'h0012, 32'h00001234);
        check_eq("ram_sh_12", ram_mem[4], 32'h1234AAEF);
        run_op(1'b0, 2'd1, 1'b0, 16'h0012, 32'd0);
        run_op(1'b0, 2'd1, 1'b0, 16'h0010, 32'd0);
        run_op(1'b0, 2'd1, 1'b1, 16'h0010, 32'd0);

        // Misaligned and illegal-size requests.
        run_op(1'b0, 2'd2, 1'b0, 16'h0013, 32'd0);
        run_op(1'b1, 2'd1, 1'b0, 16'h0011, 32'h0000BEEF);
        run_op(1'b1, 2'd3, 1'b0, 16'h0010, 32'h12345678);
        check_eq("ram_after_errors", ram_mem[4], 32'h1234AAEF);

        // Byte store interrupted by reset during its WRITE cycle.
        old_word = ref_mem[4];
        resp0    = n_resp;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_size    = 2'd0;
        bus.req_address = 16'h0010;
        bus.req_data    = 32'h00000055;
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #1;
        check_eq("abort_in_write", 32'(bus.ram_write_enable), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("abort_we_drop", 32'(bus.ram_write_enable), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("abort_ready", 32'(bus.req_ready), 32'd1);
        check_eq("abort_word", ram_mem[4], old_word);
        repeat (2) @(negedge clk);
        check_eq("abort_no_resp", 32'(n_resp - resp0), 32'd0);
        run_op(1'b0, 2'd2, 1'b0, 16'h0010, 32'd0);

        // req_valid held high across two word loads.
        exp_q.push_back(ref_mem[4]);
        exp_q.push_back(ref_mem[5]);
        acc_cnt = 0;
        rcnt    = 0;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b0;
        bus.req_size    = 2'd2;
        bus.req_address = 16'h0010;
        for (int c = 0; c < 14; c++) begin
            logic acc_now;
            acc_now = bus.req_valid && bus.req_ready;
            if (acc_now && acc_cnt < 2) acc_cyc[acc_cnt] = c;
            if (bus.resp_valid) begin
                if (rcnt < 2) resp_cyc[rcnt] = c;
                if (exp_q.size() > 0) check_eq("b2b_data", bus.resp_data, exp_q.pop_front());
                else                  check_eq("b2b_extra_resp", 32'd1, 32'd0);
                rcnt++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                acc_cnt++;
                if (acc_cnt == 1) bus.req_address = 16'h0014;
                else              idle_inputs();
            end
            @(negedge clk);
        end
        check_eq("b2b_accepts", 32'(acc_cnt), 32'd2);
        check_eq("b2b_resps", 32'(rcnt), 32'd2);
        if (acc_cnt == 2 && rcnt >= 1)
            check_eq("b2b_second_after_resp", 32'(acc_cyc[1] > resp_cyc[0]), 32'd1);
        exp_q.delete();

        // Random mix.
        for (int n = 0; n < 150; n++) begin
            logic [1:0] sz;
            sz = (($urandom_range(0, 9)) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_op(1'($urandom), sz, 1'($urandom), 16'($urandom_range(0, 255)), $urandom);
        end

        for (int i = 0; i < 64; i++) check_eq("final_ram", ram_mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator side of the word-addressed data RAM port: accepts byte/halfword/word load and store requests from the pipeline's memory stage and turns them into RAM port activity. The RAM port has a combinational read and a write committed on the clock edge. Sub-word stores become a two-step read-modify-write. Loads return sign- or zero-extended data, and misaligned accesses are rejected without touching RAM.

## Interface
- ADDR_WIDTH, 16, byte-address width; equals $bits(RamAddress)
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; 0 forces IDLE immediately
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; request accepted on posedge with req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores and word loads
- req_address  in  ADDR_WIDTH  byte address
- req_data  in  32  store data; byte uses [7:0], half uses [15:0]
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_data  out  32  load result; 0 for stores and errors
- resp_error  out  1  valid with resp_valid; 1 = misaligned or illegal size
- ram_write_enable  out  1  RAM write strobe
- ram_address  out  ADDR_WIDTH  RAM byte address, bits [1:0] always 0
- ram_in  out  32  RAM write data
- ram_out  in  32  RAM combinational read data for ram_address

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Request latch: fields are captured on accept and held until RESP exits. req_* inputs are don't-care outside the accept edge.
- Error check on accept: illegal if req_size==11, half with address[0]=1, or word with address[1:0]!=0.
- IDLE: req_ready=1 (0 while reset low). On accept:
  - error → RESP with error;
  - load → LOAD;
  - word store → WRITE with merge register = req_data;
  - byte/half store → RMW_READ.
- LOAD: ram_address = latched address & ~3, no write. At the edge, register the extracted lane into resp_data, then → RESP.
- Lane extraction is little-endian.
  - Byte k = ram_out[8k+7:8k], k = address[1:0].
  - Half at offset 0 = [15:0]; at offset 2 = [31:16].
  - Extend to 32 bits per req_unsigned.
- RMW_READ: ram_address driven as in LOAD. At the edge, the merge register gets ram_out with the addressed byte/half lanes replaced by req_data low bits, then → WRITE.
- WRITE: ram_write_enable=1, ram_in = merge register, ram_address = aligned address. The RAM commits at the edge, then → RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_error and resp_data as latched; then → IDLE.
- Outside LOAD/RMW_READ/WRITE: ram_address=0, ram_in=0, ram_write_enable=0. All RAM outputs decode from registered state only.
- One request in flight at a time; no queueing.

## Timing
- Reset (async, low): state=IDLE, resp_valid=0, resp_error=0, resp_data=0, ram_write_enable=0, ram_address=0, ram_in=0, merge/latch registers=0, req_ready=0 until reset is released.
- Latency, counted from the accept edge E0 to the resp_valid cycle:
  - error → the cycle after E0;
  - load, word store → the cycle after E1;
  - byte/half store → the cycle after E2.
- Throughput: the next accept is no earlier than the edge ending RESP + 1 cycle (req_ready only in IDLE).
- Reset asserted in any state aborts the request.
  - ram_write_enable drops combinationally, so no RAM write occurs in an interrupted WRITE cycle.
  - No resp_valid is issued for the aborted request.
- RAM word contents are modified only in WRITE, exactly once per store.

## Test plan
- Reset, SW 0x10 ← 0xDEADBEEF, then LW 0x10 → one write strobe, RAM[0x10]=0xDEADBEEF, LW resp_data=0xDEADBEEF, resp_valid 1 cycle after E1.
- SB 0x11 ← 0x000000AA over 0xDEADBEEF → RAM word 0xDEADAAEF, resp_valid cycle after E2. LB 0x11 → 0xFFFFFFAA; LBU 0x11 → 0x000000AA.
- SH 0x12 ← 0x00001234 → word 0x1234AAEF. LH 0x12 → 0x00001234; LH 0x10 → 0xFFFFAAEF; LHU 0x10 → 0x0000AAEF.
- LW 0x13, SH 0x11, req_size=11 at 0x10 → each gives resp_error=1, resp_data=0, resp_valid the cycle after E0, ram_write_enable never high, RAM unchanged.
- SB 0x10 ← 0x55, reset pulled low during the WRITE cycle → no write, word unchanged, no resp_valid, req_ready=1 after release, next LW 0x10 returns the old value.
- req_valid held high across two LW requests → second accepted only after the first's RESP cycle, exactly two resp_valid pulses, correct data order.
